dmem_port_sched: RTL and testbench

- Schedules the single data-memory port between the upper (u) and lower (l) issue lanes of the dual-issue pipeline at the memory1/memory2 boundary.
- Accepts one two-lane bundle per cycle from exec and serialises two memory ops in one bundle over two cycles.
- Tracks in-flight loads across the fixed BRAM read latency and returns load data with its destination register to writeback.
- Drives the memory1_stall, memory1_used and memory2_used signals that the front-end stall logic consumes.

---
 rtl/dmem_port_sched_if.sv | 42 ++++
 rtl/dmem_port_sched.sv | 119 +++++++++++
 tb/tb_dmem_port_sched.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_port_sched_if.sv
// Exec/BRAM/writeback bundle for the data-memory port scheduler.
// The master side is exec plus the BRAM; the slave side is the scheduler itself.
interface dmem_port_sched_if #(
  parameter int ADDR_W = 15
);
  logic              bundle_valid;
  logic              u_ld;
  logic              u_st;
  logic [31:0]       u_addr;
  logic [31:0]       u_wdata;
  logic [4:0]        u_rt;
  logic              l_ld;
  logic              l_st;
  logic [31:0]       l_addr;
  logic [31:0]       l_wdata;
  logic [4:0]        l_rt;
  logic              stall;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              ld_valid;
  logic [4:0]        ld_rt;
  logic [31:0]       ld_data;
  logic              memory1_used;
  logic              memory2_used;

  modport master (
    output bundle_valid, u_ld, u_st, u_addr, u_wdata, u_rt,
    output l_ld, l_st, l_addr, l_wdata, l_rt, mem_rdata,
    input  stall, mem_en, mem_we, mem_addr, mem_wdata,
    input  ld_valid, ld_rt, ld_data, memory1_used, memory2_used
  );

  modport slave (
    input  bundle_valid, u_ld, u_st, u_addr, u_wdata, u_rt,
    input  l_ld, l_st, l_addr, l_wdata, l_rt, mem_rdata,
    output stall, mem_en, mem_we, mem_addr, mem_wdata,
    output ld_valid, ld_rt, ld_data, memory1_used, memory2_used
  );
endinterface

// File: rtl/dmem_port_sched.sv
// Shares the single data-memory port between the u and l issue lanes, serialising
// dual-op bundles over two cycles and tracking loads across the BRAM read latency.
module dmem_port_sched #(
  parameter int ADDR_W   = 15,
  parameter int READ_LAT = 2    // legal range 1..4
) (
  input  logic              clk,
  input  logic              rst,
  dmem_port_sched_if.slave  bus
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] SECOND = 1'b1;

  typedef struct packed {
    logic              ld;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [4:0]        rt;
  } lane_op_t;

  logic [0:0] state;
  logic [0:0] state_n;
  lane_op_t   u_op;
  lane_op_t   l_op;
  lane_op_t   hold_q;
  lane_op_t   sel;
  logic       op_u;
  logic       op_l;
  logic       issue;
  logic       issue_ld;
  logic       hold_en;
  logic       stall;

  logic [READ_LAT-1:0]      pipe_v;
  logic [READ_LAT-1:0][4:0] pipe_rt;

  // Upper address bits are architecturally ignored by the port.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{bus.u_addr[31:ADDR_W], bus.l_addr[31:ADDR_W]};

  assign op_u = bus.u_ld | bus.u_st;
  assign op_l = bus.l_ld | bus.l_st;
  assign u_op = '{ld: bus.u_ld, addr: bus.u_addr[ADDR_W-1:0], wdata: bus.u_wdata, rt: bus.u_rt};
  assign l_op = '{ld: bus.l_ld, addr: bus.l_addr[ADDR_W-1:0], wdata: bus.l_wdata, rt: bus.l_rt};

  // NOTE: every signal gets its default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    issue   = 1'b0;
    sel     = '0;
    stall   = 1'b0;
    hold_en = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (bus.bundle_valid) begin
            if (op_u) begin
              issue = 1'b1;
              sel   = u_op;
              if (op_l) begin
                stall   = 1'b1;
                hold_en = 1'b1;
                state_n = SECOND;
              end
            end else if (op_l) begin
              issue = 1'b1;
              sel   = l_op;
            end
          end
        end
        SECOND: begin
          // exec is still presenting the same bundle, so bundle_valid is ignored
          issue   = 1'b1;
          sel     = hold_q;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign issue_ld = issue & sel.ld;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      hold_q <= '0;
      pipe_v <= '0;
    end else begin
      state <= state_n;
      if (hold_en) hold_q <= l_op;
      pipe_v[0] <= issue_ld;
      for (int i = 1; i < READ_LAT; i++) pipe_v[i] <= pipe_v[i-1];
    end
  end

  // NOTE: the rt payload is left unreset; it is only observed when its valid
  // bit is set, and the valids are cleared on reset.
  always_ff @(posedge clk) begin
    pipe_rt[0] <= sel.rt;
    for (int i = 1; i < READ_LAT; i++) pipe_rt[i] <= pipe_rt[i-1];
  end

  assign bus.stall        = stall;
  assign bus.mem_en       = issue;
  assign bus.mem_we       = issue & ~sel.ld;
  assign bus.mem_addr     = sel.addr;
  assign bus.mem_wdata    = sel.wdata;
  assign bus.ld_valid     = pipe_v[READ_LAT-1];
  assign bus.ld_rt        = pipe_rt[READ_LAT-1];
  assign bus.ld_data      = bus.mem_rdata;
  assign bus.memory1_used = issue_ld;
  assign bus.memory2_used = pipe_v[READ_LAT-1];

endmodule

// File: tb/tb_dmem_port_sched.sv
// Directed bench for dmem_port_sched with a 2-cycle BRAM model behind the port.
module tb_dmem_port_sched;

  localparam int ADDR_W = 15;
  localparam int READ_LAT = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  dmem_port_sched_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_port_sched #(.ADDR_W(ADDR_W), .READ_LAT(READ_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // BRAM model: unwritten words read as 0xBEEF_0000 | addr; two-cycle read latency.
  logic [31:0] bram [64];
  logic [63:0] written = '0;
  logic [31:0] rd_q1;
  logic [31:0] rd_q2;

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) begin
      bram[bus.mem_addr[5:0]]    <= bus.mem_wdata;
      written[bus.mem_addr[5:0]] <= 1'b1;
    end
    rd_q1 <= written[bus.mem_addr[5:0]] ? bram[bus.mem_addr[5:0]]
                                        : (32'hBEEF_0000 | 32'(bus.mem_addr[5:0]));
    rd_q2 <= rd_q1;
  end
  assign bus.mem_rdata = rd_q2;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_bus();
    bus.bundle_valid = 1'b0;
    bus.u_ld = 1'b0; bus.u_st = 1'b0; bus.u_addr = '0; bus.u_wdata = '0; bus.u_rt = '0;
    bus.l_ld = 1'b0; bus.l_st = 1'b0; bus.l_addr = '0; bus.l_wdata = '0; bus.l_rt = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_bus();
    bus.bundle_valid = 1'b1; bus.u_ld = 1'b1; bus.l_st = 1'b1;
    next_cycle();
    @(negedge clk);
    checks++;
    if ({bus.stall, bus.mem_en} !== 2'b00) begin
      failures++;
      $display("FAIL reset_gating: stall,mem_en=%b expected 00", {bus.stall, bus.mem_en});
    end
    next_cycle();
    rst = 1'b0;
    clear_bus();
    @(negedge clk);
    checks++;
    if ({bus.stall, bus.mem_en, bus.mem_we, bus.ld_valid, bus.memory1_used, bus.memory2_used} !== 6'b0) begin
      failures++;
      $display("FAIL reset_state: stall,en,we,ldv,m1,m2=%b expected 000000",
               {bus.stall, bus.mem_en, bus.mem_we, bus.ld_valid, bus.memory1_used, bus.memory2_used});
    end
    next_cycle();
  endtask

  task automatic test_single_load();
    bus.bundle_valid = 1'b1; bus.u_ld = 1'b1; bus.u_addr = 32'h10; bus.u_rt = 5'd3;
    @(negedge clk);
    checks++;
    if ({bus.stall, bus.mem_en, bus.mem_we, bus.mem_addr, bus.memory1_used} !== {3'b010, 15'h10, 1'b1}) begin
      failures++;
      $display("FAIL single_issue: stall,en,we,addr,m1=%b,%b,%b,%h,%b expected 0,1,0,0010,1",
               bus.stall, bus.mem_en, bus.mem_we, bus.mem_addr, bus.memory1_used);
    end
    next_cycle();
    clear_bus();
    @(negedge clk);
    checks++;
    if ({bus.mem_en, bus.memory1_used, bus.ld_valid} !== 3'b000) begin
      failures++;
      $display("FAIL single_c1: en,m1,ldv=%b expected 000", {bus.mem_en, bus.memory1_used, bus.ld_valid});
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({bus.ld_valid, bus.memory2_used, bus.ld_rt, bus.ld_data} !== {2'b11, 5'd3, 32'hBEEF_0010}) begin
      failures++;
      $display("FAIL single_return: ldv,m2,rt,data=%b,%b,%0d,%h expected 1,1,3,beef0010",
               bus.ld_valid, bus.memory2_used, bus.ld_rt, bus.ld_data);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus.ld_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_c3: ld_valid=%b expected 0", bus.ld_valid);
    end
    next_cycle();
  endtask

  task automatic test_store_then_load();
    bus.bundle_valid = 1'b1;
    bus.u_st = 1'b1; bus.u_addr = 32'd5; bus.u_wdata = 32'h0000_DEAD;
    bus.l_ld = 1'b1; bus.l_addr = 32'd5; bus.l_rt = 5'd7;
    @(negedge clk);
    checks++;
    if ({bus.stall, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {3'b111, 15'd5, 32'h0000_DEAD}) begin
      failures++;
      $display("FAIL pair_first: stall,en,we,addr,wdata=%b,%b,%b,%h,%h expected 1,1,1,0005,0000dead",
               bus.stall, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({bus.stall, bus.mem_en, bus.mem_we, bus.mem_addr, bus.memory1_used} !== {3'b010, 15'd5, 1'b1}) begin
      failures++;
      $display("FAIL pair_second: stall,en,we,addr,m1=%b,%b,%b,%h,%b expected 0,1,0,0005,1",
               bus.stall, bus.mem_en, bus.mem_we, bus.mem_addr, bus.memory1_used);
    end
    next_cycle();
    clear_bus();
    @(negedge clk);
    checks++;
    if ({bus.mem_en, bus.ld_valid} !== 2'b00) begin
      failures++;
      $display("FAIL pair_c2: en,ldv=%b expected 00", {bus.mem_en, bus.ld_valid});
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({bus.ld_valid, bus.ld_rt, bus.ld_data} !== {1'b1, 5'd7, 32'h0000_DEAD}) begin
      failures++;
      $display("FAIL pair_return: ldv,rt,data=%b,%0d,%h expected 1,7,0000dead",
               bus.ld_valid, bus.ld_rt, bus.ld_data);
    end
    next_cycle();
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [4:0]  exp_rt   [3];
    logic [31:0] exp_data [3];
    exp_rt   = '{5'd1, 5'd2, 5'd3};
    exp_data = '{32'hBEEF_0001, 32'hBEEF_0002, 32'hBEEF_0003};
    for (int c = 0; c < 6; c++) begin
      clear_bus();
      // Middle load goes on the l lane alone to cover the l-only path.
      if (c == 0) begin bus.bundle_valid = 1'b1; bus.u_ld = 1'b1; bus.u_addr = 32'd1; bus.u_rt = 5'd1; end
      if (c == 1) begin bus.bundle_valid = 1'b1; bus.l_ld = 1'b1; bus.l_addr = 32'd2; bus.l_rt = 5'd2; end
      if (c == 2) begin bus.bundle_valid = 1'b1; bus.u_ld = 1'b1; bus.u_addr = 32'd3; bus.u_rt = 5'd3; end
      @(negedge clk);
      checks++;
      if (bus.stall !== 1'b0) begin
        failures++;
        $display("FAIL b2b_stall c%0d: stall=%b expected 0", c, bus.stall);
      end
      checks++;
      if (c >= 2 && c <= 4) begin
        if ({bus.ld_valid, bus.ld_rt, bus.ld_data} !== {1'b1, exp_rt[c-2], exp_data[c-2]}) begin
          failures++;
          $display("FAIL b2b_return c%0d: ldv,rt,data=%b,%0d,%h expected 1,%0d,%h",
                   c, bus.ld_valid, bus.ld_rt, bus.ld_data, exp_rt[c-2], exp_data[c-2]);
        end
      end else if (bus.ld_valid !== 1'b0) begin
        failures++;
        $display("FAIL b2b_idle c%0d: ld_valid=%b expected 0", c, bus.ld_valid);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_in_second();
    bus.bundle_valid = 1'b1;
    bus.u_ld = 1'b1; bus.u_addr = 32'h20; bus.u_rt = 5'd4;
    bus.l_ld = 1'b1; bus.l_addr = 32'h21; bus.l_rt = 5'd9;
    @(negedge clk);
    checks++;
    if ({bus.stall, bus.mem_en, bus.mem_addr} !== {2'b11, 15'h20}) begin
      failures++;
      $display("FAIL rst2_first: stall,en,addr=%b,%b,%h expected 1,1,0020", bus.stall, bus.mem_en, bus.mem_addr);
    end
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.stall, bus.mem_en} !== 2'b00) begin
      failures++;
      $display("FAIL rst2_during: stall,en=%b expected 00", {bus.stall, bus.mem_en});
    end
    next_cycle();
    rst = 1'b0;
    clear_bus();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.stall, bus.mem_en, bus.ld_valid, bus.memory1_used, bus.memory2_used} !== 5'b0) begin
        failures++;
        $display("FAIL rst2_after c%0d: stall,en,ldv,m1,m2=%b expected 00000",
                 c, {bus.stall, bus.mem_en, bus.ld_valid, bus.memory1_used, bus.memory2_used});
      end
      next_cycle();
    end
  endtask

  task automatic test_no_op();
    bus.bundle_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.stall, bus.mem_en, bus.memory1_used, bus.memory2_used} !== 4'b0) begin
      failures++;
      $display("FAIL no_op: stall,en,m1,m2=%b expected 0000",
               {bus.stall, bus.mem_en, bus.memory1_used, bus.memory2_used});
    end
    next_cycle();
    clear_bus();
  endtask

  task automatic test_addr_truncate();
    bus.bundle_valid = 1'b1;
    bus.u_st = 1'b1; bus.u_addr = 32'h8001_0003; bus.u_wdata = 32'h0000_1234;
    @(negedge clk);
    checks++;
    if ({bus.mem_en, bus.mem_we, bus.mem_addr} !== {2'b11, 15'h0003}) begin
      failures++;
      $display("FAIL trunc_store: en,we,addr=%b,%b,%h expected 1,1,0003", bus.mem_en, bus.mem_we, bus.mem_addr);
    end
    next_cycle();
    clear_bus();
    bus.bundle_valid = 1'b1;
    bus.l_ld = 1'b1; bus.l_addr = 32'hFFFF_8003; bus.l_rt = 5'd12;
    @(negedge clk);
    checks++;
    if ({bus.stall, bus.mem_en, bus.mem_we, bus.mem_addr} !== {3'b010, 15'h0003}) begin
      failures++;
      $display("FAIL trunc_load: stall,en,we,addr=%b,%b,%b,%h expected 0,1,0,0003",
               bus.stall, bus.mem_en, bus.mem_we, bus.mem_addr);
    end
    next_cycle();
    clear_bus();
    next_cycle();
    @(negedge clk);
    checks++;
    if ({bus.ld_valid, bus.ld_rt, bus.ld_data} !== {1'b1, 5'd12, 32'h0000_1234}) begin
      failures++;
      $display("FAIL trunc_return: ldv,rt,data=%b,%0d,%h expected 1,12,00001234",
               bus.ld_valid, bus.ld_rt, bus.ld_data);
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_store_then_load();
    test_back_to_back();
    test_reset_in_second();
    test_no_op();
    test_addr_truncate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
